// File: rtl/bytewise_divider.sv
// Streaming byte-wise long division of an arbitrary-length dividend by a
// run-time modulus, using a Barrett reduction step for each dividend byte.
module bytewise_divider #(
  parameter int unsigned M0LEN = 14,
  parameter int unsigned SHIFT = 27,
  parameter int unsigned LENW  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LENW-1:0]  len,
  input  logic [M0LEN-1:0] m0,
  input  logic [SHIFT-1:0] m0_inverse,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [M0LEN-1:0] remainder,
  output logic             done,
  output logic             busy
);

  localparam int unsigned DW = 2 * M0LEN;
  localparam int unsigned PW = DW + SHIFT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_EMIT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  cnt_q;
  logic [M0LEN-1:0] m0_q;
  logic [SHIFT-1:0] inv_q;
  logic [M0LEN-1:0] r_q;
  logic [DW-1:0]    dividend_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [7:0]       out_byte_q;
  logic             out_last_q;
  logic [M0LEN-1:0] remainder_q;
  logic             done_q;
  logic             busy_q;

  logic [PW-1:0]    prod;
  logic [DW-1:0]    m0_ext;
  logic [DW-1:0]    q_est;
  logic [DW-1:0]    rem_est;
  logic [7:0]       quot_d;
  logic [M0LEN-1:0] rem_d;

  // Barrett step: the floored reciprocal underestimates the quotient by at
  // most two, so two conditional corrections give the exact result.
  always_comb begin
    m0_ext  = DW'(m0_q);
    prod    = PW'(dividend_q) * PW'(inv_q);
    q_est   = DW'(prod >> SHIFT);
    rem_est = dividend_q - DW'(q_est * m0_ext);
    if (rem_est >= m0_ext) begin
      rem_est = rem_est - m0_ext;
      q_est   = q_est + DW'(1);
    end
    if (rem_est >= m0_ext) begin
      rem_est = rem_est - m0_ext;
      q_est   = q_est + DW'(1);
    end
    quot_d = 8'(q_est);
    rem_d  = M0LEN'(rem_est);
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      m0_q        <= '0;
      inv_q       <= '0;
      r_q         <= '0;
      dividend_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_last_q  <= 1'b0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q <= len;
            m0_q  <= m0;
            inv_q <= m0_inverse;
            r_q   <= '0;
            cnt_q <= '0;
            if (len == '0) begin
              remainder_q <= '0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            dividend_q <= DW'({r_q, in_byte});
            in_ready_q <= 1'b0;
            state_q    <= S_DIV;
          end
        end
        S_DIV: begin
          r_q         <= rem_d;
          out_byte_q  <= quot_d;
          out_valid_q <= 1'b1;
          out_last_q  <= (cnt_q == len_q - LENW'(1));
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cnt_q       <= cnt_q + LENW'(1);
            if (out_last_q) begin
              remainder_q <= r_q;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  assign remainder = remainder_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bytewise_divider.sv
// Randomized bench for bytewise_divider against a plain long-division model.
module tb_bytewise_divider;

  localparam int unsigned M0LEN = 14;
  localparam int unsigned SHIFT = 27;
  localparam int unsigned LENW  = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LENW-1:0]  len;
  logic [M0LEN-1:0] m0;
  logic [SHIFT-1:0] m0_inverse;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_byte;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_last;
  logic [M0LEN-1:0] remainder;
  logic             done;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] job_bytes[$];

  bytewise_divider #(.M0LEN(M0LEN), .SHIFT(SHIFT), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .m0(m0),
    .m0_inverse(m0_inverse), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .remainder(remainder),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned inv_of(input int unsigned d);
    return int'((64'd1 << SHIFT) / 64'(d));
  endfunction

  // Runs one job from IDLE; stall < 0 picks a random consumer stall per byte.
  task automatic run_job(input int unsigned m0v, input int unsigned lenv, input int stall);
    longint unsigned r = 0;
    longint unsigned d;
    longint unsigned q;
    int unsigned ns;
    m0 = M0LEN'(m0v); m0_inverse = SHIFT'(inv_of(m0v)); len = LENW'(lenv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (lenv == 0) begin
      check_eq("len0_done", done, 1);
      check_eq("len0_rem", remainder, 0);
      check_eq("len0_valid", out_valid, 0);
      check_eq("len0_busy", busy, 0);
      @(negedge clk);
      check_eq("len0_done_clr", done, 0);
      check_eq("len0_valid2", out_valid, 0);
      return;
    end
    for (int i = 0; i < int'(lenv); i++) begin
      for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
      check_eq("in_ready_wait", in_ready, 1);
      check_eq("busy_load", busy, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_byte  = job_bytes[i];
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      check_eq("div_valid", out_valid, 0);
      check_eq("div_in_ready", in_ready, 0);
      @(negedge clk);
      check_eq("latency_valid", out_valid, 1);
      d = r * 256 + longint'(job_bytes[i]);
      q = d / longint'(m0v);
      r = d % longint'(m0v);
      ns = (stall < 0) ? $urandom_range(0, 3) : stall;
      for (int s = 0; s < int'(ns); s++) begin
        check_eq("stall_byte", out_byte, q);
        check_eq("stall_last", out_last, (i == int'(lenv) - 1));
        check_eq("stall_in_ready", in_ready, 0);
        start = (s == 1);
        m0 = M0LEN'($urandom); m0_inverse = SHIFT'($urandom); len = LENW'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      check_eq("out_valid", out_valid, 1);
      check_eq("out_byte", out_byte, q);
      check_eq("out_last", out_last, (i == int'(lenv) - 1));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check_eq("done", done, 1);
    check_eq("remainder", remainder, r);
    check_eq("done_busy", busy, 0);
    check_eq("done_valid", out_valid, 0);
    len = LENW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_clr", done, 0);
    @(negedge clk);
    check_eq("start_in_done_ignored", busy, 0);
    check_eq("idle_in_ready", in_ready, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_remainder"}, remainder, 0);
    check_eq({tag, "_out_byte"}, out_byte, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; m0 = '0; m0_inverse = '0;
    in_valid = 1'b0; in_byte = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    job_bytes = '{8'h12, 8'h34};
    run_job(4591, 2, 0);
    job_bytes = '{8'hFF};
    run_job(2, 1, 0);
    job_bytes = '{8'h12, 8'h34};
    run_job(4591, 2, 5);
    run_job(4591, 0, 0);

    // Abort a 4-byte job in EMIT, then confirm a clean restart.
    m0 = 14'd4591; m0_inverse = SHIFT'(inv_of(4591)); len = LENW'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_byte = 8'hA5;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    in_valid = 1'b0;
    check_eq("abort_reached_emit", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    job_bytes = '{8'hFF};
    run_job(4591, 1, 0);

    for (int j = 0; j < 25; j++) begin
      int unsigned mv = $urandom_range(2, 16383);
      int unsigned lv = $urandom_range(1, 64);
      job_bytes = {};
      for (int b = 0; b < int'(lv); b++) job_bytes.push_back(8'($urandom));
      run_job(mv, lv, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bytewise_divider.md
BYTEWISE_DIVIDER -- requirements
Module: bytewise_divider

Interface
REQ-001 SHALL have parameter M0LEN, default 14, modulus width in bits.
REQ-002 SHALL have parameter SHIFT, default 27, reciprocal width in bits (Barrett shift).
REQ-003 SHALL have parameter LENW, default 11, byte-count width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  begin a division job; sampled only in IDLE.
REQ-007 len  input  LENW  number of dividend bytes in the job; latched on accepted start.
REQ-008 m0  input  M0LEN  divisor, valid range 2..2^M0LEN-1; latched on accepted start.
REQ-009 m0_inverse  input  SHIFT  floor(2^SHIFT/m0); latched on accepted start.
REQ-010 in_valid  input  1  in_byte is valid.
REQ-011 in_ready  output  1  block accepts in_byte this cycle.
REQ-012 in_byte  input  8  dividend byte, most significant byte first.
REQ-013 out_valid  output  1  out_byte is valid.
REQ-014 out_ready  input  1  consumer accepts out_byte this cycle.
REQ-015 out_byte  output  8  quotient byte, most significant byte first.
REQ-016 out_last  output  1  out_byte is the final quotient byte of the job.
REQ-017 remainder  output  M0LEN  final remainder, held stable while done is high.
REQ-018 done  output  1  job complete; remainder valid.
REQ-019 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-020 FSM SHALL have states IDLE, LOAD, DIV, EMIT, DONE.
REQ-021 Transition IDLE->LOAD on start with len!=0: latch len, m0, m0_inverse; clear running remainder r to 0; clear byte counter.
REQ-022 Transition IDLE->DONE on start with len==0: remainder=0; no out_valid is generated.
REQ-023 In LOAD, in_ready SHALL be 1; on in_valid&in_ready, register dividend = r*256 + in_byte (zero-extended to 2*M0LEN bits); go to DIV.
REQ-024 In DIV, dividend, latched m0 and latched m0_inverse SHALL feed one combinational barrett instance; register quotient[7:0] and remainder into r; go to EMIT.
REQ-025 Quotient per step SHALL be < 256 because r < m0; the upper quotient bits SHALL be ignored.
REQ-026 In EMIT, out_valid=1 and out_byte holds the registered quotient; out_last=1 iff the counter equals len-1.
REQ-027 On out_valid&out_ready in EMIT: increment the counter; go to DONE if last, else to LOAD.
REQ-028 out_byte and out_last SHALL be held stable while out_valid&!out_ready.
REQ-029 Latency: a byte accepted in cycle t SHALL produce out_valid in cycle t+2.
REQ-030 Throughput: at most one byte per 3 cycles; in_ready SHALL be 0 outside LOAD.
REQ-031 DONE: done=1, remainder=r; go to IDLE on the next cycle; a start in that cycle is ignored.
REQ-032 start outside IDLE SHALL be ignored; latched parameters SHALL NOT change mid-job.
REQ-033 The counter SHALL support len up to 2^LENW-1 without wrap.

Reset
REQ-034 On rst_n low (any state, including mid-job): FSM=IDLE; in_ready=0, out_valid=0, out_last=0, done=0, busy=0; remainder=0, out_byte=0, r=0, counter=0.
REQ-035 After rst_n deasserts, the first start SHALL be accepted and the aborted job SHALL leave no residual output.

Verification
REQ-036 m0=4591, m0_inverse=29234, len=2, bytes 0x12,0x34 -> out_byte 0x00 then 0x01 (out_last on second), done with remainder=69.
REQ-037 m0=2, m0_inverse=67108864, len=1, byte 0xFF -> out_byte 0x7F with out_last=1, remainder=1.
REQ-038 Same job as REQ-036 with out_ready held 0 for 5 cycles at each EMIT -> identical bytes, stable during stall, in_ready=0 throughout stall.
REQ-039 start with len=0 -> no out_valid, done=1 one cycle later with remainder=0; start pulsed while busy -> ignored.
REQ-040 rst_n asserted during EMIT of a 4-byte job -> all outputs 0 immediately; new job m0=4591, len=1, byte 0xFF -> out_byte 0x00, remainder=255.
REQ-041 Random m0 in 2..16383 with matching inverse, len 1..64, random bytes and random out_ready -> quotient bytes and remainder match a big-integer model.
